// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
//
// Single-clock FIFO used between the symbol-encoding stage and the bit-packing
// stage of the Huffman coder to absorb rate mismatch. Width and depth are
// parameters; the threshold is programmable at run time; overflow/underflow
// errors are sticky until cleared.
//
// Parameters
//   DATA_W  data word width in bits (>=1)
//   DEPTH   number of storage words (power of two, >=4)
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   wr / rd         write / read requests
//   data_in         write data, captured on an accepted write
//   thr_level       threshold compared against the fill count
//   clr_err         synchronous clear of the sticky error flags
//   data_out        registered read data (1-cycle read latency)
//   fifo_full       count == DEPTH
//   fifo_empty      count == 0
//   fifo_threshold  count >= thr_level
//   fifo_overflow   sticky: write attempted while full
//   fifo_underflow  sticky: read attempted while empty
//   fill_level      current word count, 0..DEPTH
// -----------------------------------------------------------------------------
module fifo_sync_param #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr,
   input  logic                         rd,
   input  logic [DATA_W-1:0]            data_in,
   input  logic [$clog2(DEPTH):0]       thr_level,
   input  logic                         clr_err,
   output logic [DATA_W-1:0]            data_out,
   output logic                         fifo_full,
   output logic                         fifo_empty,
   output logic                         fifo_threshold,
   output logic                         fifo_overflow,
   output logic                         fifo_underflow,
   output logic [$clog2(DEPTH):0]       fill_level
);

   localparam int ADDR_W = $clog2(DEPTH);

   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_MAX = DEPTH[ADDR_W:0];

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic              wa;
   logic              ra;

   // Status flags come straight from the registered count, so they move only
   // on a clock edge or when thr_level itself changes.
   assign fifo_full      = (count_q == CNT_MAX);
   assign fifo_empty     = (count_q == '0);
   assign fifo_threshold = (count_q >= thr_level);
   assign fill_level     = count_q;
   assign data_out       = data_out_q;
   assign fifo_overflow  = ovf_q;
   assign fifo_underflow = unf_q;

   always_comb begin
      // Acceptance is judged against the state before the edge: on a full
      // FIFO the slot freed by a concurrent read is not reused this cycle, and
      // on an empty FIFO a concurrent write is not bypassed to data_out.
      wa = wr & ~fifo_full;
      ra = rd & ~fifo_empty;

      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      data_out_d = data_out_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;

      if (wa) begin
         wptr_d = wptr_q + PTR_ONE;
      end
      if (ra) begin
         rptr_d     = rptr_q + PTR_ONE;
         data_out_d = mem_q[rptr_q];
      end

      case ({wa, ra})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // Clear first so that a coincident error event wins.
      if (clr_err) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      if (wr & fifo_full) begin
         ovf_d = 1'b1;
      end
      if (rd & fifo_empty) begin
         unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         data_out_q <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         data_out_q <= data_out_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   // Storage array is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wa) begin
         mem_q[wptr_q] <= data_in;
      end
   end

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk;
   logic              rst_n;
   logic              wr;
   logic              rd;
   logic [DATA_W-1:0] data_in;
   logic [ADDR_W:0]   thr_level;
   logic              clr_err;
   logic [DATA_W-1:0] data_out;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_threshold;
   logic              fifo_overflow;
   logic              fifo_underflow;
   logic [ADDR_W:0]   fill_level;

   int checks;
   int failures;

   fifo_sync_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wr             (wr),
      .rd             (rd),
      .data_in        (data_in),
      .thr_level      (thr_level),
      .clr_err        (clr_err),
      .data_out       (data_out),
      .fifo_full      (fifo_full),
      .fifo_empty     (fifo_empty),
      .fifo_threshold (fifo_threshold),
      .fifo_overflow  (fifo_overflow),
      .fifo_underflow (fifo_underflow),
      .fill_level     (fill_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle with the given request pattern, requests dropped afterwards.
   task automatic op(input logic w, input logic r, input logic [DATA_W-1:0] d);
      wr      = w;
      rd      = r;
      data_in = d;
      tick();
      wr      = 1'b0;
      rd      = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (fifo_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
      checks++;
      if (fifo_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
      checks++;
      if (fill_level !== 5'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
      checks++;
      if (data_out !== 32'd0) begin failures++; $display("FAIL reset_dout got=%h exp=0", data_out); end
      checks++;
      if (fifo_overflow !== 1'b0 || fifo_underflow !== 1'b0) begin
         failures++; $display("FAIL reset_err got=%b%b exp=00", fifo_overflow, fifo_underflow);
      end
      checks++;
      if (fifo_threshold !== 1'b0) begin failures++; $display("FAIL reset_thr8 got=%b exp=0", fifo_threshold); end
      thr_level = 5'd0;
      #1;
      checks++;
      if (fifo_threshold !== 1'b1) begin failures++; $display("FAIL reset_thr0 got=%b exp=1", fifo_threshold); end
      thr_level = 5'd8;
      #1;
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 16; i++) begin
         op(1'b1, 1'b0, i);
         checks++;
         if (fill_level !== i[4:0]) begin failures++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, fill_level, i); end
         checks++;
         if (fifo_threshold !== (i >= 8)) begin failures++; $display("FAIL fill_thr[%0d] got=%b exp=%b", i, fifo_threshold, (i >= 8)); end
         checks++;
         if (fifo_full !== (i == 16)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, fifo_full, (i == 16)); end
      end
      op(1'b1, 1'b0, 32'd17);
      checks++;
      if (fifo_overflow !== 1'b1) begin failures++; $display("FAIL fill_ovf got=%b exp=1", fifo_overflow); end
      checks++;
      if (fill_level !== 5'd16) begin failures++; $display("FAIL fill_ovf_level got=%0d exp=16", fill_level); end
      thr_level = 5'd17;
      #1;
      checks++;
      if (fifo_threshold !== 1'b0) begin failures++; $display("FAIL thr_above_depth got=%b exp=0", fifo_threshold); end
      thr_level = 5'd16;
      #1;
      checks++;
      if (fifo_threshold !== 1'b1) begin failures++; $display("FAIL thr_eq_depth got=%b exp=1", fifo_threshold); end
      thr_level = 5'd8;
      #1;
   endtask

   task automatic test_drain();
      for (int i = 1; i <= 16; i++) begin
         op(1'b0, 1'b1, '0);
         checks++;
         if (data_out !== i) begin failures++; $display("FAIL drain_data[%0d] got=%0d exp=%0d", i, data_out, i); end
         checks++;
         if (fill_level !== 5'(16 - i)) begin failures++; $display("FAIL drain_level[%0d] got=%0d exp=%0d", i, fill_level, 16 - i); end
      end
      op(1'b0, 1'b1, '0);
      checks++;
      if (fifo_underflow !== 1'b1) begin failures++; $display("FAIL drain_unf got=%b exp=1", fifo_underflow); end
      checks++;
      if (data_out !== 32'd16) begin failures++; $display("FAIL drain_hold got=%0d exp=16", data_out); end
      checks++;
      if (fifo_empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", fifo_empty); end
   endtask

   task automatic test_err_clear();
      checks++;
      if (fifo_overflow !== 1'b1 || fifo_underflow !== 1'b1) begin
         failures++; $display("FAIL clr_pre got=%b%b exp=11", fifo_overflow, fifo_underflow);
      end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      checks++;
      if (fifo_overflow !== 1'b0 || fifo_underflow !== 1'b0) begin
         failures++; $display("FAIL clr_post got=%b%b exp=00", fifo_overflow, fifo_underflow);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 10; i++) op(1'b1, 1'b0, 32'h50 + i);
      for (int i = 0; i < 10; i++) begin
         op(1'b0, 1'b1, '0);
         checks++;
         if (data_out !== 32'h50 + i) begin failures++; $display("FAIL wrap_a[%0d] got=%h exp=%h", i, data_out, 32'h50 + i); end
      end
      for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 32'h100 + i);
      checks++;
      if (fifo_full !== 1'b1) begin failures++; $display("FAIL wrap_full got=%b exp=1", fifo_full); end
      for (int i = 0; i < 16; i++) begin
         op(1'b0, 1'b1, '0);
         checks++;
         if (data_out !== 32'h100 + i) begin failures++; $display("FAIL wrap_b[%0d] got=%h exp=%h", i, data_out, 32'h100 + i); end
      end
      checks++;
      if (fifo_empty !== 1'b1 || fifo_underflow !== 1'b0) begin
         failures++; $display("FAIL wrap_end got=%b%b exp=10", fifo_empty, fifo_underflow);
      end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 32'h200 + i);
      op(1'b1, 1'b1, 32'h2FF);
      checks++;
      if (fill_level !== 5'd5) begin failures++; $display("FAIL sim_mid_level got=%0d exp=5", fill_level); end
      checks++;
      if (data_out !== 32'h200) begin failures++; $display("FAIL sim_mid_data got=%h exp=200", data_out); end
      for (int i = 1; i < 5; i++) begin
         op(1'b0, 1'b1, '0);
         checks++;
         if (data_out !== 32'h200 + i) begin failures++; $display("FAIL sim_mid_drain[%0d] got=%h exp=%h", i, data_out, 32'h200 + i); end
      end
      op(1'b0, 1'b1, '0);
      checks++;
      if (data_out !== 32'h2FF) begin failures++; $display("FAIL sim_mid_last got=%h exp=2ff", data_out); end
      // Empty: write accepted, read rejected, no bypass.
      op(1'b1, 1'b1, 32'hAA);
      checks++;
      if (fill_level !== 5'd1) begin failures++; $display("FAIL sim_empty_level got=%0d exp=1", fill_level); end
      checks++;
      if (fifo_underflow !== 1'b1) begin failures++; $display("FAIL sim_empty_unf got=%b exp=1", fifo_underflow); end
      checks++;
      if (data_out !== 32'h2FF) begin failures++; $display("FAIL sim_empty_data got=%h exp=2ff", data_out); end
      // Full: read accepted, write rejected.
      for (int i = 0; i < 15; i++) op(1'b1, 1'b0, 32'h300 + i);
      checks++;
      if (fill_level !== 5'd16) begin failures++; $display("FAIL sim_full_pre got=%0d exp=16", fill_level); end
      op(1'b1, 1'b1, 32'h3FF);
      checks++;
      if (fill_level !== 5'd15) begin failures++; $display("FAIL sim_full_level got=%0d exp=15", fill_level); end
      checks++;
      if (fifo_overflow !== 1'b1) begin failures++; $display("FAIL sim_full_ovf got=%b exp=1", fifo_overflow); end
      checks++;
      if (data_out !== 32'hAA) begin failures++; $display("FAIL sim_full_data got=%h exp=aa", data_out); end
   endtask

   task automatic test_clr_coincide();
      op(1'b1, 1'b0, 32'h3AA);
      checks++;
      if (fifo_full !== 1'b1) begin failures++; $display("FAIL coin_full got=%b exp=1", fifo_full); end
      clr_err = 1'b1;
      op(1'b1, 1'b0, 32'h3BB);
      clr_err = 1'b0;
      checks++;
      if (fifo_overflow !== 1'b1) begin failures++; $display("FAIL coin_ovf got=%b exp=1", fifo_overflow); end
      checks++;
      if (fifo_underflow !== 1'b0) begin failures++; $display("FAIL coin_unf got=%b exp=0", fifo_underflow); end
      // 0x3FF was rejected, so after 0x300..0x30E comes 0x3AA.
      op(1'b0, 1'b1, '0);
      checks++;
      if (data_out !== 32'h300) begin failures++; $display("FAIL coin_order got=%h exp=300", data_out); end
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 32'h400 + i);
      op(1'b0, 1'b1, '0);
      checks++;
      if (fill_level !== 5'd7 || data_out !== 32'h400) begin
         failures++; $display("FAIL rstmid_pre got=%0d/%h exp=7/400", fill_level, data_out);
      end
      wr      = 1'b1;
      data_in = 32'h4FF;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (fill_level !== 5'd0) begin failures++; $display("FAIL rstmid_level got=%0d exp=0", fill_level); end
      checks++;
      if (data_out !== 32'd0) begin failures++; $display("FAIL rstmid_data got=%h exp=0", data_out); end
      checks++;
      if (fifo_empty !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%b exp=1", fifo_empty); end
      tick();
      checks++;
      if (fill_level !== 5'd0) begin failures++; $display("FAIL rstmid_hold got=%0d exp=0", fill_level); end
      wr    = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      wr        = 1'b0;
      rd        = 1'b0;
      data_in   = '0;
      thr_level = 5'd8;
      clr_err   = 1'b0;
      test_reset();
      test_fill();
      test_drain();
      test_err_clear();
      test_wrap();
      test_simultaneous();
      test_clr_coincide();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
